// File: rtl/rv32_pkg.sv
// Shared types for the RV32 memory stage: FSM state, load/store encodings and packet layouts.
package rv32_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RESP, DONE} mau_state_t;

  localparam logic [2:0] LT_LB  = 3'b000;
  localparam logic [2:0] LT_LH  = 3'b001;
  localparam logic [2:0] LT_LW  = 3'b010;
  localparam logic [2:0] LT_LBU = 3'b011;
  localparam logic [2:0] LT_LHU = 3'b100;

  localparam logic [1:0] ST_SB = 2'b00;
  localparam logic [1:0] ST_SH = 2'b01;
  localparam logic [1:0] ST_SW = 2'b10;

  localparam logic [1:0] W_BYTE = 2'd0;
  localparam logic [1:0] W_HALF = 2'd1;
  localparam logic [1:0] W_WORD = 2'd2;

  typedef struct packed {
    logic        is_load;
    logic        is_store;
    logic [31:0] addr;
    logic [31:0] data;
  } rv32_mem_packet_t;

  typedef struct packed {
    logic [2:0] load_type;
    logic [1:0] store_type;
  } rv32_ex_control_packet_t;

  typedef struct packed {
    logic        wb_enable;
    logic [4:0]  rd;
    logic [31:0] wb_data;
  } rv32_ex2mem_wb_packet_t;

  // Unknown encodings fall back to a full-word access.
  function automatic logic [1:0] access_width(logic is_store, logic [2:0] lt, logic [1:0] st);
    if (is_store) begin
      case (st)
        ST_SB:   return W_BYTE;
        ST_SH:   return W_HALF;
        default: return W_WORD;
      endcase
    end
    case (lt)
      LT_LB, LT_LBU: return W_BYTE;
      LT_LH, LT_LHU: return W_HALF;
      default:       return W_WORD;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(logic [1:0] width, logic [1:0] off);
    case (width)
      W_BYTE:  return 4'b0001 << off;
      W_HALF:  return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/load_align_ext.sv
// Picks the addressed byte/halfword out of a read word and sign- or zero-extends it.
module load_align_ext
  import rv32_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  load_type,
  output logic [31:0] data
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    case (load_type)
      LT_LB:   data = {{24{shifted[7]}}, shifted[7:0]};
      LT_LH:   data = {{16{shifted[15]}}, shifted[15:0]};
      LT_LBU:  data = {24'd0, shifted[7:0]};
      LT_LHU:  data = {16'd0, shifted[15:0]};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory stage: turns one EX load/store packet into a data-memory transaction and one WB result.
//   state     | meaning
//   IDLE      | ready for a packet from EX
//   REQ       | dmem_req held until grant or timeout
//   WAIT_RESP | load granted, waiting for rvalid or timeout
//   DONE      | out_valid pulse, then back to IDLE
module mem_access_unit
  import rv32_pkg::*;
#(
  parameter int unsigned RESP_TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  rv32_mem_packet_t        mem_packet,
  input  rv32_ex_control_packet_t ex_control_packet,
  input  rv32_ex2mem_wb_packet_t  wb_in,
  output logic                    dmem_req,
  output logic                    dmem_we,
  output logic [31:0]             dmem_addr,
  output logic [3:0]              dmem_be,
  output logic [31:0]             dmem_wdata,
  input  logic                    dmem_gnt,
  input  logic                    dmem_rvalid,
  input  logic [31:0]             dmem_rdata,
  output logic                    out_valid,
  output rv32_ex2mem_wb_packet_t  wb_out,
  output logic                    misaligned,
  output logic                    bus_error
);

  localparam logic [31:0] TMO_LAST = 32'(RESP_TIMEOUT - 1);

  mau_state_t             state;
  logic [31:0]            tmo_cnt;
  logic                   q_is_store;
  logic [1:0]             q_off;
  logic [2:0]             q_load_type;
  rv32_ex2mem_wb_packet_t wb_q;

  logic [1:0]  cap_width;
  logic        cap_mis;
  logic [31:0] cap_wdata;
  logic [31:0] load_data;

  assign in_ready = (state == IDLE);

  always_comb begin
    cap_width = access_width(mem_packet.is_store, ex_control_packet.load_type,
                             ex_control_packet.store_type);
    cap_mis   = ((cap_width == W_HALF) && mem_packet.addr[0]) ||
                ((cap_width == W_WORD) && (mem_packet.addr[1:0] != 2'b00));
    case (cap_width)
      W_BYTE:  cap_wdata = {4{mem_packet.data[7:0]}};
      W_HALF:  cap_wdata = {2{mem_packet.data[15:0]}};
      default: cap_wdata = mem_packet.data;
    endcase
  end

  load_align_ext u_load_align_ext (
    .rdata     (dmem_rdata),
    .offset    (q_off),
    .load_type (q_load_type),
    .data      (load_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      tmo_cnt     <= '0;
      q_is_store  <= 1'b0;
      q_off       <= '0;
      q_load_type <= '0;
      wb_q        <= '0;
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      dmem_addr   <= '0;
      dmem_be     <= '0;
      dmem_wdata  <= '0;
      out_valid   <= 1'b0;
      wb_out      <= '0;
      misaligned  <= 1'b0;
      bus_error   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tmo_cnt <= '0;
          if (in_valid) begin
            q_is_store  <= mem_packet.is_store;
            q_off       <= mem_packet.addr[1:0];
            q_load_type <= ex_control_packet.load_type;
            wb_q        <= wb_in;
            if (!mem_packet.is_load && !mem_packet.is_store) begin
              state      <= DONE;
              out_valid  <= 1'b1;
              wb_out     <= wb_in;
              misaligned <= 1'b0;
              bus_error  <= 1'b0;
            end else if (cap_mis) begin
              state             <= DONE;
              out_valid         <= 1'b1;
              wb_out            <= wb_in;
              wb_out.wb_enable  <= 1'b0;
              misaligned        <= 1'b1;
              bus_error         <= 1'b0;
            end else begin
              state      <= REQ;
              dmem_req   <= 1'b1;
              dmem_we    <= mem_packet.is_store;
              dmem_addr  <= {mem_packet.addr[31:2], 2'b00};
              dmem_be    <= lane_mask(cap_width, mem_packet.addr[1:0]);
              dmem_wdata <= cap_wdata;
            end
          end
        end
        REQ: begin
          // Grant wins over a same-cycle timeout; any rvalid here is ignored.
          if (dmem_gnt) begin
            dmem_req <= 1'b0;
            tmo_cnt  <= '0;
            if (q_is_store) begin
              state            <= DONE;
              out_valid        <= 1'b1;
              wb_out           <= wb_q;
              wb_out.wb_enable <= 1'b0;
              misaligned       <= 1'b0;
              bus_error        <= 1'b0;
            end else begin
              state <= WAIT_RESP;
            end
          end else if (tmo_cnt == TMO_LAST) begin
            dmem_req         <= 1'b0;
            tmo_cnt          <= '0;
            state            <= DONE;
            out_valid        <= 1'b1;
            wb_out           <= wb_q;
            wb_out.wb_enable <= 1'b0;
            misaligned       <= 1'b0;
            bus_error        <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 32'd1;
          end
        end
        WAIT_RESP: begin
          if (dmem_rvalid) begin
            tmo_cnt        <= '0;
            state          <= DONE;
            out_valid      <= 1'b1;
            wb_out         <= wb_q;
            wb_out.wb_data <= load_data;
            misaligned     <= 1'b0;
            bus_error      <= 1'b0;
          end else if (tmo_cnt == TMO_LAST) begin
            tmo_cnt          <= '0;
            state            <= DONE;
            out_valid        <= 1'b1;
            wb_out           <= wb_q;
            wb_out.wb_enable <= 1'b0;
            misaligned       <= 1'b0;
            bus_error        <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 32'd1;
          end
        end
        default: begin
          tmo_cnt   <= '0;
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed plus randomized bench for mem_access_unit against a byte-lane arithmetic model.
module tb_mem_access_unit;
  import rv32_pkg::*;

  localparam int unsigned TMO = 4;

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic in_ready;
  rv32_mem_packet_t        mem_packet;
  rv32_ex_control_packet_t ex_control_packet;
  rv32_ex2mem_wb_packet_t  wb_in;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        out_valid;
  rv32_ex2mem_wb_packet_t wb_out;
  logic        misaligned, bus_error;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.RESP_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .mem_packet(mem_packet), .ex_control_packet(ex_control_packet), .wb_in(wb_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata), .out_valid(out_valid), .wb_out(wb_out),
    .misaligned(misaligned), .bus_error(bus_error)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: access size in bytes drives alignment, lanes, replication and extraction.
  function automatic void model(input logic ld, input logic st, input logic [2:0] lt,
                                input logic [1:0] stt, input logic [31:0] addr,
                                input logic [31:0] data, input logic [31:0] rdata,
                                output logic mis, output logic [3:0] be,
                                output logic [31:0] wd, output logic [31:0] lres);
    int size;
    int off;
    bit sgn;
    logic [31:0] v;
    if (st) size = (stt == 2'b00) ? 1 : (stt == 2'b01) ? 2 : 4;
    else    size = (lt == 3'b000 || lt == 3'b011) ? 1 : (lt == 3'b001 || lt == 3'b100) ? 2 : 4;
    sgn = (lt == 3'b000 || lt == 3'b001);
    off = int'(addr[1:0]);
    mis = (ld || st) && ((off % size) != 0);
    be  = 4'(((2 ** size) - 1) << (off & (4 - size)));
    if (size == 1)      wd = 32'(data[7:0]) * 32'h0101_0101;
    else if (size == 2) wd = 32'(data[15:0]) * 32'h0001_0001;
    else                wd = data;
    v = rdata >> (8 * off);
    if (size == 1) begin
      v = v & 32'hFF;
      if (sgn && v[7]) v = v | 32'hFFFF_FF00;
    end else if (size == 2) begin
      v = v & 32'hFFFF;
      if (sgn && v[15]) v = v | 32'hFFFF_0000;
    end
    lres = v;
  endfunction

  task automatic txn(input string tag, input logic ld, input logic st, input logic [2:0] lt,
                     input logic [1:0] stt, input logic [31:0] addr, input logic [31:0] data,
                     input logic [4:0] rd, input logic wben, input logic [31:0] wbd,
                     input int gdly, input int rdly, input logic [31:0] rdata,
                     input bit rvalid_with_gnt);
    logic mis;
    logic [3:0] be;
    logic [31:0] wd, lres, exp_data;
    model(ld, st, lt, stt, addr, data, rdata, mis, be, wd, lres);
    exp_data = wbd;
    @(negedge clk);
    chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    mem_packet = '{is_load: ld, is_store: st, addr: addr, data: data};
    ex_control_packet = '{load_type: lt, store_type: stt};
    wb_in = '{wb_enable: wben, rd: rd, wb_data: wbd};
    step();
    in_valid = 1'b0;
    if ((!ld && !st) || mis) begin
      chk({tag, " out_valid"}, 32'(out_valid), 32'd1);
      chk({tag, " no_req"}, 32'(dmem_req), 32'd0);
      chk({tag, " misaligned"}, 32'(misaligned), 32'(mis));
      chk({tag, " wb_enable"}, 32'(wb_out.wb_enable), 32'(wben && !mis));
      chk({tag, " wb_data"}, wb_out.wb_data, wbd);
      chk({tag, " rd"}, 32'(wb_out.rd), 32'(rd));
    end else begin
      chk({tag, " req"}, 32'(dmem_req), 32'd1);
      chk({tag, " we"}, 32'(dmem_we), 32'(st));
      chk({tag, " addr"}, dmem_addr, {addr[31:2], 2'b00});
      chk({tag, " be"}, 32'(dmem_be), 32'(be));
      if (st) chk({tag, " wdata"}, dmem_wdata, wd);
      for (int i = 0; i < gdly; i++) step();
      if (gdly > 0) begin
        chk({tag, " req_held"}, 32'(dmem_req), 32'd1);
        chk({tag, " addr_held"}, dmem_addr, {addr[31:2], 2'b00});
      end
      dmem_gnt = 1'b1;
      if (rvalid_with_gnt) begin
        dmem_rvalid = 1'b1;
        dmem_rdata  = ~rdata;
      end
      step();
      dmem_gnt = 1'b0;
      dmem_rvalid = 1'b0;
      chk({tag, " req_drop"}, 32'(dmem_req), 32'd0);
      if (st) begin
        chk({tag, " out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, " wb_enable"}, 32'(wb_out.wb_enable), 32'd0);
        chk({tag, " wb_data"}, wb_out.wb_data, wbd);
      end else begin
        chk({tag, " wait_no_out"}, 32'(out_valid), 32'd0);
        for (int i = 0; i < rdly; i++) step();
        dmem_rvalid = 1'b1;
        dmem_rdata  = rdata;
        step();
        dmem_rvalid = 1'b0;
        dmem_rdata  = 32'hDEAD_BEEF;
        exp_data = lres;
        chk({tag, " out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, " wb_enable"}, 32'(wb_out.wb_enable), 32'(wben));
        chk({tag, " wb_data"}, wb_out.wb_data, lres);
        chk({tag, " rd"}, 32'(wb_out.rd), 32'(rd));
      end
      chk({tag, " bus_error"}, 32'(bus_error), 32'd0);
    end
    step();
    chk({tag, " pulse_end"}, 32'(out_valid), 32'd0);
    chk({tag, " wb_hold"}, wb_out.wb_data, exp_data);
  endtask

  task automatic timeout_txn(input string tag, input bit grant);
    int cnt;
    @(negedge clk);
    in_valid = 1'b1;
    mem_packet = '{is_load: 1'b1, is_store: 1'b0, addr: 32'h5000, data: 32'h0};
    ex_control_packet = '{load_type: LT_LW, store_type: ST_SW};
    wb_in = '{wb_enable: 1'b1, rd: 5'd9, wb_data: 32'h1234_5678};
    step();
    in_valid = 1'b0;
    if (grant) begin
      dmem_gnt = 1'b1;
      step();
      dmem_gnt = 1'b0;
    end
    cnt = 0;
    while (cnt < 20 && !out_valid) begin
      cnt++;
      step();
    end
    chk({tag, " wait_cycles"}, 32'(cnt), grant ? 32'(TMO) : 32'(TMO));
    chk({tag, " req_low"}, 32'(dmem_req), 32'd0);
    chk({tag, " out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, " bus_error"}, 32'(bus_error), 32'd1);
    chk({tag, " wb_enable"}, 32'(wb_out.wb_enable), 32'd0);
    step();
    chk({tag, " pulse_end"}, 32'(out_valid), 32'd0);
    chk({tag, " err_hold"}, 32'(bus_error), 32'd1);
  endtask

  initial begin
    logic [2:0] lt;
    logic [1:0] stt;
    int kind;
    rst = 1'b1;
    in_valid = 1'b0;
    mem_packet = '0;
    ex_control_packet = '0;
    wb_in = '0;
    dmem_gnt = 1'b0;
    dmem_rvalid = 1'b0;
    dmem_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst dmem_req", 32'(dmem_req), 32'd0);
    chk("rst dmem_we", 32'(dmem_we), 32'd0);
    chk("rst dmem_addr", dmem_addr, 32'd0);
    chk("rst dmem_be", 32'(dmem_be), 32'd0);
    chk("rst dmem_wdata", dmem_wdata, 32'd0);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst wb_out", 32'(wb_out.wb_enable) | 32'(wb_out.rd) | wb_out.wb_data, 32'd0);
    chk("rst flags", {30'd0, misaligned, bus_error}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("post_rst in_ready", 32'(in_ready), 32'd1);

    txn("sb", 0, 1, LT_LB, ST_SB, 32'h1003, 32'h0000_00AB, 5'd1, 1, 32'h7, 2, 0, 0, 0);
    chk("sb spec be_addr", {dmem_addr[31:4], dmem_be}, {28'h0000100, 4'b1000});
    chk("sb spec wdata", dmem_wdata, 32'hABAB_ABAB);
    txn("lb", 1, 0, LT_LB, ST_SB, 32'h2001, 0, 5'd2, 1, 0, 1, 1, 32'h0000_F000, 0);
    chk("lb spec data", wb_out.wb_data, 32'hFFFF_FFF0);
    txn("lbu", 1, 0, LT_LBU, ST_SB, 32'h2001, 0, 5'd3, 1, 0, 0, 0, 32'h0000_F000, 0);
    chk("lbu spec data", wb_out.wb_data, 32'h0000_00F0);
    txn("lh", 1, 0, LT_LH, ST_SB, 32'h3002, 0, 5'd4, 1, 0, 1, 2, 32'h8001_0000, 1);
    chk("lh spec data", wb_out.wb_data, 32'hFFFF_8001);
    chk("lh spec be", 32'(dmem_be), 32'b1100);
    txn("lw_mis", 1, 0, LT_LW, ST_SB, 32'h4002, 0, 5'd5, 1, 32'h55, 0, 0, 0, 0);
    txn("pass", 0, 0, LT_LW, ST_SW, 32'h4002, 0, 5'd6, 1, 32'hCAFE_F00D, 0, 0, 0, 0);
    txn("sh_hi", 0, 1, LT_LB, ST_SH, 32'h6002, 32'h1234_BEEF, 5'd7, 1, 0, 0, 0, 0, 0);
    txn("sw", 0, 1, LT_LB, ST_SW, 32'h6004, 32'h0BAD_CAFE, 5'd8, 1, 0, 1, 0, 0, 0);

    timeout_txn("tmo_req", 0);
    timeout_txn("tmo_wait", 1);

    for (int n = 0; n < 24; n++) begin
      kind = int'($urandom_range(0, 4));
      lt   = 3'($urandom_range(0, 4));
      stt  = 2'($urandom_range(0, 2));
      txn($sformatf("rnd%0d", n), kind == 1 || kind == 2, kind >= 3, lt, stt, $urandom,
          $urandom, 5'($urandom), 1'($urandom), $urandom, int'($urandom_range(0, 2)),
          int'($urandom_range(0, 2)), $urandom, 1'($urandom));
    end

    // Reset in the middle of a load, then a stray rvalid.
    @(negedge clk);
    in_valid = 1'b1;
    mem_packet = '{is_load: 1'b1, is_store: 1'b0, addr: 32'h7000, data: 32'h0};
    ex_control_packet = '{load_type: LT_LW, store_type: ST_SW};
    wb_in = '{wb_enable: 1'b1, rd: 5'd10, wb_data: 32'h0};
    step();
    in_valid = 1'b0;
    dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0;
    step();
    rst = 1'b1;
    #1;
    chk("midrst req", 32'(dmem_req), 32'd0);
    chk("midrst wb_out", wb_out.wb_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata = 32'h1111_2222;
    step();
    dmem_rvalid = 1'b0;
    chk("midrst in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk("midrst no_out", 32'(out_valid), 32'd0);
      step();
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
